// File: rtl/przesuniecie_arbiter.sv
// Round-robin sequencer sharing one combinational arithmetic shift unit
// between N_REQ requesters. Each request is latched into the shifter
// operand registers, the shifter is given one settle cycle, and the
// captured result is returned as a tagged response with backpressure.
module przesuniecie_arbiter #(
    parameter int BITS  = 32,
    parameter int N_REQ = 2,
    parameter int CNT_W = 16,
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_REQ-1:0]      i_req_valid,
    output logic [N_REQ-1:0]      o_req_ready,
    input  logic [N_REQ*BITS-1:0] i_req_A,
    input  logic [N_REQ*BITS-1:0] i_req_B,
    output logic [BITS-1:0]       o_sh_arg_A,
    output logic [BITS-1:0]       o_sh_arg_B,
    input  logic [BITS-1:0]       i_sh_result,
    input  logic                  i_sh_error,
    input  logic                  i_sh_overflow,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic [BITS-1:0]       o_rsp_result,
    output logic                  o_rsp_error,
    output logic                  o_rsp_overflow,
    output logic [CNT_W-1:0]      o_cnt_done,
    output logic [CNT_W-1:0]      o_cnt_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [BITS-1:0]   arg_a_q, arg_a_d;
    logic [BITS-1:0]   arg_b_q, arg_b_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [BITS-1:0]   rsp_result_q, rsp_result_d;
    logic              rsp_error_q, rsp_error_d;
    logic              rsp_overflow_q, rsp_overflow_d;
    logic [CNT_W-1:0]  cnt_done_q, cnt_done_d;
    logic [CNT_W-1:0]  cnt_err_q, cnt_err_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;

    // Pick the first valid requester after the last winner, wrapping around.
    always_comb begin : grant_scan
        int cand;
        // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(last_grant_q) + off) % N_REQ;
            if (!grant_found && i_req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    // Next-state and datapath updates for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        arg_a_d        = arg_a_q;
        arg_b_d        = arg_b_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_error_d    = rsp_error_q;
        rsp_overflow_d = rsp_overflow_q;
        cnt_done_d     = cnt_done_q;
        cnt_err_d      = cnt_err_q;
        o_req_ready    = '0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    o_req_ready[grant_idx] = 1'b1;
                    arg_a_d      = i_req_A[grant_idx*BITS +: BITS];
                    arg_b_d      = i_req_B[grant_idx*BITS +: BITS];
                    rsp_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // Shifter has had a full cycle to settle on the registered operands.
                rsp_result_d   = i_sh_result;
                rsp_error_d    = i_sh_error;
                rsp_overflow_d = i_sh_overflow;
                state_d        = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                    if (cnt_done_q != '1) begin
                        cnt_done_d = cnt_done_q + 1'b1;
                    end
                    if ((rsp_error_q || rsp_overflow_q) && (cnt_err_q != '1)) begin
                        cnt_err_d = cnt_err_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; last_grant starts at the top so req 0 wins first.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (i_rst) begin
            state_q        <= IDLE;
            last_grant_q   <= ID_W'(N_REQ - 1);
            arg_a_q        <= '0;
            arg_b_q        <= '0;
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_error_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            cnt_done_q     <= '0;
            cnt_err_q      <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            arg_a_q        <= arg_a_d;
            arg_b_q        <= arg_b_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_error_q    <= rsp_error_d;
            rsp_overflow_q <= rsp_overflow_d;
            cnt_done_q     <= cnt_done_d;
            cnt_err_q      <= cnt_err_d;
        end
    end

    assign o_sh_arg_A     = arg_a_q;
    assign o_sh_arg_B     = arg_b_q;
    assign o_rsp_valid    = (state_q == RESP);
    assign o_rsp_id       = rsp_id_q;
    assign o_rsp_result   = rsp_result_q;
    assign o_rsp_error    = rsp_error_q;
    assign o_rsp_overflow = rsp_overflow_q;
    assign o_cnt_done     = cnt_done_q;
    assign o_cnt_err      = cnt_err_q;

endmodule

// File: tb/tb_przesuniecie_arbiter.sv
// Scoreboard bench for przesuniecie_arbiter: directed requests push their
// hand-computed responses into a queue, a negedge monitor pops and compares
// on every response handshake.
module tb_przesuniecie_arbiter;

    localparam int BITS  = 32;
    localparam int N_REQ = 2;

    logic              i_clk;
    logic              i_rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [63:0]       req_a;
    logic [63:0]       req_b;
    logic [31:0]       sh_arg_a, sh_arg_b;
    logic [31:0]       sh_result;
    logic              sh_error, sh_overflow;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic [31:0]       rsp_result;
    logic              rsp_error, rsp_overflow;
    logic [15:0]       cnt_done, cnt_err;

    // Second instance with 4-bit counters to observe saturation.
    logic [1:0]        s_req_ready;
    logic [31:0]       s_arg_a, s_arg_b, s_rsp_result;
    logic              s_rsp_valid, s_rsp_error, s_rsp_overflow;
    logic [0:0]        s_rsp_id;
    logic [3:0]        s_cnt_done, s_cnt_err;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] res;
        logic        err;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    przesuniecie_arbiter #(.BITS(BITS), .N_REQ(N_REQ), .CNT_W(16)) u_dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_A(req_a), .i_req_B(req_b),
        .o_sh_arg_A(sh_arg_a), .o_sh_arg_B(sh_arg_b),
        .i_sh_result(sh_result), .i_sh_error(sh_error), .i_sh_overflow(sh_overflow),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(rsp_id), .o_rsp_result(rsp_result),
        .o_rsp_error(rsp_error), .o_rsp_overflow(rsp_overflow),
        .o_cnt_done(cnt_done), .o_cnt_err(cnt_err)
    );

    przesuniecie_arbiter #(.BITS(BITS), .N_REQ(N_REQ), .CNT_W(4)) u_dut4 (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(req_valid), .o_req_ready(s_req_ready),
        .i_req_A(req_a), .i_req_B(req_b),
        .o_sh_arg_A(s_arg_a), .o_sh_arg_B(s_arg_b),
        .i_sh_result(sh_result), .i_sh_error(sh_error), .i_sh_overflow(sh_overflow),
        .o_rsp_valid(s_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_id(s_rsp_id), .o_rsp_result(s_rsp_result),
        .o_rsp_error(s_rsp_error), .o_rsp_overflow(s_rsp_overflow),
        .o_cnt_done(s_cnt_done), .o_cnt_err(s_cnt_err)
    );

    // Shift unit stand-in: arithmetic A <<< B, error on negative B,
    // overflow when significant bits are lost or B >= BITS.
    always_comb begin
        sh_result   = '0;
        sh_error    = 1'b0;
        sh_overflow = 1'b0;
        if (sh_arg_b[31]) begin
            sh_error = 1'b1;
        end else if (sh_arg_b >= 32'd32) begin
            sh_overflow = (sh_arg_a != '0);
        end else begin
            sh_result   = sh_arg_a << sh_arg_b;
            sh_overflow = (($signed(sh_result) >>> sh_arg_b) != $signed(sh_arg_a));
        end
    end

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response must match the oldest expectation.
    always @(negedge i_clk) begin
        if (!i_rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id",       32'(rsp_id),       32'(e.id));
                check("rsp_result",   rsp_result,        e.res);
                check("rsp_error",    32'(rsp_error),    32'(e.err));
                check("rsp_overflow", 32'(rsp_overflow), 32'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Issue one request on port k; returns after the grant edge (in the EXEC cycle).
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic err, input logic ovf,
                          output int waits);
        exp_t e;
        int   n;
        e.id  = 1'(k);
        e.res = res;
        e.err = err;
        e.ovf = ovf;
        sb.push_back(e);
        tick();
        req_a[k*32 +: 32] = a;
        req_b[k*32 +: 32] = b;
        req_valid[k]      = 1'b1;
        n = 0;
        @(negedge i_clk);
        while (!req_ready[k] && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        check("grant_seen", 32'(n < 20), 32'd1);
        check("ready_onehot", 32'(req_ready), 32'(2'b01 << k));
        waits = n;
        tick();
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge i_clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int   w;
        int   n;
        int   gc[4];
        exp_t e;

        i_rst     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;

        // Reset state.
        @(negedge i_clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_ready",     32'(req_ready), 32'd0);
        check("reset_cnt_done",  32'(cnt_done),  32'd0);
        check("reset_cnt_err",   32'(cnt_err),   32'd0);
        check("reset_arg_a",     sh_arg_a,       32'd0);
        check("reset_rsp_id",    32'(rsp_id),    32'd0);

        // 1: req0 1<<<3 = 8, granted immediately, response two cycles later.
        run_op(0, 32'd1, 32'd3, 32'd8, 1'b0, 1'b0, w);
        check("t1_same_cycle_grant", 32'(w), 32'd0);
        @(negedge i_clk);
        check("t1_exec_no_valid", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge i_clk);
        check("t1_rsp_valid_t2", 32'(rsp_valid), 32'd1);
        tick();
        @(negedge i_clk);
        check("t1_cnt_done", 32'(cnt_done), 32'd1);
        check("t1_back_idle", 32'(rsp_valid), 32'd0);

        // 3: negative shift amount from req1 -> error.
        run_op(1, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, w);
        wait_drain();
        tick();
        @(negedge i_clk);
        check("t3_cnt_done", 32'(cnt_done), 32'd2);
        check("t3_cnt_err",  32'(cnt_err),  32'd1);

        // 4: 0x4000_0000 <<< 2 overflows; response held under backpressure.
        rsp_ready = 1'b0;
        run_op(0, 32'h4000_0000, 32'd2, 32'd0, 1'b0, 1'b1, w);
        n = 0;
        @(negedge i_clk);
        while (!rsp_valid && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        check("t4_rsp_seen", 32'(n < 10), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_valid",  32'(rsp_valid),    32'd1);
            check("t4_hold_id",     32'(rsp_id),       32'd0);
            check("t4_hold_result", rsp_result,        32'd0);
            check("t4_hold_ovf",    32'(rsp_overflow), 32'd1);
            check("t4_hold_ready",  32'(req_ready),    32'd0);
            check("t4_hold_cnt",    32'(cnt_done),     32'd2);
            tick();
            if (i < 4) begin
                req_valid[1] = 1'b1;
            end else begin
                req_valid[1] = 1'b0;
                rsp_ready    = 1'b1;
            end
            @(negedge i_clk);
        end
        wait_drain();
        tick();
        @(negedge i_clk);
        check("t4_cnt_done", 32'(cnt_done), 32'd3);
        check("t4_cnt_err",  32'(cnt_err),  32'd2);
        check("t4_arg_hold", sh_arg_a,      32'h4000_0000);

        // 5: reset while in EXEC discards the op; then 2: round-robin 0,1,0,1.
        tick();
        req_a[31:0] = 32'd7;
        req_b[31:0] = 32'd1;
        req_valid   = 2'b01;
        n = 0;
        @(negedge i_clk);
        while (!req_ready[0] && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        check("t5_pre_grant", 32'(n < 10), 32'd1);
        tick();
        req_valid = 2'b00;
        i_rst     = 1'b1;
        tick();
        i_rst     = 1'b0;
        req_a     = {32'd3, 32'd2};
        req_b     = {32'd2, 32'd1};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            e.id  = 1'(i % 2);
            e.res = (i % 2 == 0) ? 32'd4 : 32'd12;
            e.err = 1'b0;
            e.ovf = 1'b0;
            sb.push_back(e);
        end
        @(negedge i_clk);
        check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t5_cnt_done",  32'(cnt_done),  32'd0);
        check("t5_cnt_err",   32'(cnt_err),   32'd0);
        check("t5_arg_a",     sh_arg_a,       32'd0);
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 20) begin
                @(negedge i_clk);
                n++;
            end
            check("t2_grant", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            gc[i] = cyc;
            if (i > 0) check("t2_spacing", 32'(gc[i] - gc[i-1]), 32'd3);
            if (i == 3) begin
                tick();
                req_valid = 2'b00;
            end else begin
                @(negedge i_clk);
            end
        end
        wait_drain();
        tick();
        @(negedge i_clk);
        check("t2_cnt_done", 32'(cnt_done), 32'd4);

        // 6: 17 ops; 16-bit counter reads 17, 4-bit counter saturates at 15.
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            run_op(k % 2, 32'(k), 32'd1, 32'(2 * k), 1'b0, 1'b0, w);
            wait_drain();
        end
        tick();
        @(negedge i_clk);
        check("t6_cnt_done16", 32'(cnt_done),   32'd17);
        check("t6_cnt_done4",  32'(s_cnt_done), 32'd15);
        check("t6_cnt_err4",   32'(s_cnt_err),  32'd0);
        check("end_sb_empty",  32'(sb.size()),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
